// File: rtl/gray_scale_sequencer.sv
// rtl/gray_scale_sequencer.sv - frame sequencer feeding the RGB555-to-grayscale core
// Optional feature macro: GRAY_SEQ_FRAME_CNT_EN adds an 8-bit frame_count_o output.
module gray_scale_sequencer #(
  parameter int IMG_WIDTH       = 8,
  parameter int IMG_HEIGHT      = 8,
  parameter int MAX_PIXEL_BITS  = 15,
  parameter int PIXEL_WIDTH_OUT = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       frame_start_i,
  input  logic                       px_valid_i,
  output logic                       px_ready_o,
  input  logic [MAX_PIXEL_BITS-1:0]  px_rgb_i,
  output logic                       core_start_o,
  output logic [MAX_PIXEL_BITS-1:0]  core_px_rgb_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] core_px_gray_i,
  output logic                       gray_valid_o,
  input  logic                       gray_ready_i,
  output logic [PIXEL_WIDTH_OUT-1:0] gray_o,
  output logic                       eol_o,
  output logic                       eof_o,
  output logic                       busy_o,
  output logic                       frame_done_o
`ifdef GRAY_SEQ_FRAME_CNT_EN
  ,
  output logic [7:0]                 frame_count_o
`endif
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [MAX_PIXEL_BITS-1:0]   last_rgb_q;
  logic                        gray_valid_q;
  logic                        eol_q, eof_q;
  logic [COL_W-1:0]            col_q;
  logic [ROW_W-1:0]            row_q;
  logic                        accept;
  logic                        handshake;
  logic                        col_last, last_px;

  // Upstream may only advance when the held result is free or leaving this cycle.
  assign px_ready_o    = (state_q == ST_RUN) && (!gray_valid_q || gray_ready_i);
  assign accept        = px_valid_i && px_ready_o;
  assign handshake     = gray_valid_q && gray_ready_i;
  assign col_last      = (col_q == COL_LAST);
  assign last_px       = col_last && (row_q == ROW_LAST);

  // While stalled the core re-registers the previous pixel so its result holds.
  assign core_px_rgb_o = accept ? px_rgb_i : last_rgb_q;
  assign gray_o        = core_px_gray_i;
  assign gray_valid_o  = gray_valid_q;
  assign eol_o         = eol_q;
  assign eof_o         = eof_q;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and per-state control; core start stays high through stalls.
  always_comb begin
    state_d      = state_q;
    core_start_o = 1'b0;
    busy_o       = 1'b1;
    frame_done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (frame_start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        core_start_o = 1'b1;
        if (accept && last_px) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        core_start_o = 1'b1;
        if (handshake) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output-valid register with line/frame tags; accept wins over handshake so streaming has no bubble.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_rgb_q   <= '0;
      gray_valid_q <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
    end else if (accept) begin
      last_rgb_q   <= px_rgb_i;
      gray_valid_q <= 1'b1;
      eol_q        <= col_last;
      eof_q        <= last_px;
    end else if (handshake) begin
      gray_valid_q <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
    end
  end

  // Column/row position of the next pixel; a frame start honoured in IDLE rewinds it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end else if (state_q == ST_IDLE && frame_start_i) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

`ifdef GRAY_SEQ_FRAME_CNT_EN
  logic [7:0] frame_count_q;
  assign frame_count_o = frame_count_q;

  // Completed-frame counter, bumped once per DONE visit and wrapping at 255.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                 frame_count_q <= 8'd0;
    else if (state_q == ST_DONE) frame_count_q <= frame_count_q + 8'd1;
  end
`endif

endmodule

// File: tb/tb_gray_scale_sequencer.sv
// tb/tb_gray_scale_sequencer.sv - scoreboard bench for gray_scale_sequencer
// Optional feature macro: GRAY_SEQ_FRAME_CNT_EN enables frame_count_o checks.
module tb_gray_scale_sequencer;

  localparam int W   = 2;
  localparam int H   = 2;
  localparam int NPX = W * H;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        frame_start_i;
  logic        px_valid_i;
  logic        px_ready_o;
  logic [14:0] px_rgb_i;
  logic        core_start_o;
  logic [14:0] core_px_rgb_o;
  logic [7:0]  core_px_gray_i;
  logic        gray_valid_o;
  logic        gray_ready_i = 1'b0;
  logic [7:0]  gray_o;
  logic        eol_o, eof_o, busy_o, frame_done_o;
`ifdef GRAY_SEQ_FRAME_CNT_EN
  logic [7:0]  frame_count_o;
`endif

  typedef struct packed {
    logic [7:0] gray;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pix_idx = 0;
  int   ready_mode = 0;
  logic done_exp = 1'b0;

  gray_scale_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .MAX_PIXEL_BITS(15), .PIXEL_WIDTH_OUT(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .frame_start_i(frame_start_i),
    .px_valid_i(px_valid_i), .px_ready_o(px_ready_o), .px_rgb_i(px_rgb_i),
    .core_start_o(core_start_o), .core_px_rgb_o(core_px_rgb_o),
    .core_px_gray_i(core_px_gray_i), .gray_valid_o(gray_valid_o),
    .gray_ready_i(gray_ready_i), .gray_o(gray_o), .eol_o(eol_o), .eof_o(eof_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
`ifdef GRAY_SEQ_FRAME_CNT_EN
    , .frame_count_o(frame_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Luma weights chosen so full red/green/blue/white give 69/139/22/230.
  function automatic logic [7:0] ref_gray(input logic [14:0] p);
    int r, g, b;
    r = int'(p[14:10]);
    g = int'(p[9:5]);
    b = int'(p[4:0]);
    return 8'((570 * r + 1148 * g + 182 * b) / 256);
  endfunction

  // Stand-in for the grayscale core: one register stage, zeroed while start is low.
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i)            core_px_gray_i <= 8'd0;
    else if (!core_start_o) core_px_gray_i <= 8'd0;
    else                    core_px_gray_i <= ref_gray(core_px_rgb_o);
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  // Downstream ready pattern: 0 = always ready, 1 = random, 2 = held off.
  always @(posedge clk_i) begin
    #2;
    case (ready_mode)
      0:       gray_ready_i = 1'b1;
      1:       gray_ready_i = 1'($urandom_range(0, 1));
      default: gray_ready_i = 1'b0;
    endcase
  end

  // Monitor: compares every presented gray pixel with the queue head; pops on handshake.
  always @(negedge clk_i) begin
    if (reset_i) begin
      done_exp = 1'b0;
    end else begin
      checks++;
      if (frame_done_o !== done_exp) begin
        errors++;
        $display("FAIL frame_done cyc %0d got %0b exp %0b", cyc, frame_done_o, done_exp);
      end
      done_exp = 1'b0;
      if (gray_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_gray cyc %0d got gray=%0d valid with no pixel expected", cyc, gray_o);
        end else begin
          if ({gray_o, eol_o, eof_o} !== exp_q[0]) begin
            errors++;
            $display("FAIL scoreboard cyc %0d got gray=%0d eol=%0b eof=%0b exp gray=%0d eol=%0b eof=%0b",
                     cyc, gray_o, eol_o, eof_o, exp_q[0].gray, exp_q[0].eol, exp_q[0].eof);
          end
          if (gray_ready_i) begin
            done_exp = exp_q[0].eof;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [14:0] rgb);
    exp_t e;
    e.gray = ref_gray(rgb);
    e.eol  = ((pix_idx % W) == W - 1);
    e.eof  = (pix_idx == NPX - 1);
    exp_q.push_back(e);
    pix_idx++;
  endtask

  task automatic start_frame();
    @(posedge clk_i); #1;
    frame_start_i = 1'b1;
    pix_idx       = 0;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
  endtask

  // Offers one pixel and waits for acceptance; valid is left high for back-to-back use.
  task automatic send(input logic [14:0] rgb, output int t_acc);
    bit ok;
    ok         = 1'b0;
    px_valid_i = 1'b1;
    px_rgb_i   = rgb;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk_i);
      if (px_ready_o) ok = 1'b1;
      else begin
        @(posedge clk_i); #1;
      end
    end
    t_acc = cyc;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got px_ready_o=0 for 200 cycles exp 1");
    end else begin
      push_exp(rgb);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 100 && !idle; n++) begin
      @(negedge clk_i);
      idle = !busy_o;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL idle_timeout got busy_o=1 after 100 cycles exp 0");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d pixels not handed off exp 0", exp_q.size());
    end
    @(posedge clk_i); #1;
  endtask

  task automatic run_frame(input bit mid_pulse);
    int t;
    start_frame();
    for (int k = 0; k < NPX; k++) begin
      send(15'($urandom()), t);
      if (mid_pulse && k == 1) begin
        px_valid_i    = 1'b0;
        frame_start_i = 1'b1;
        @(posedge clk_i); #1;
        frame_start_i = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        px_valid_i = 1'b0;
        px_rgb_i   = 15'($urandom());
        @(posedge clk_i); #1;
      end
    end
    px_valid_i = 1'b0;
    wait_idle();
  endtask

  task automatic check_count(input int f);
`ifdef GRAY_SEQ_FRAME_CNT_EN
    checks++;
    if (frame_count_o !== 8'(f)) begin
      errors++;
      $display("FAIL frame_count got %0d exp %0d", frame_count_o, f);
    end
`else
    if (f < 0) $display("frame index %0d", f);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t_first;
    int t_done;
    bit got;
    reset_i = 1'b1; frame_start_i = 1'b0; px_valid_i = 1'b0; px_rgb_i = 15'd0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({px_ready_o, gray_valid_o, eol_o, eof_o, frame_done_o, core_start_o, busy_o} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000000",
               {px_ready_o, gray_valid_o, eol_o, eof_o, frame_done_o, core_start_o, busy_o});
    end
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if ({px_ready_o, gray_valid_o, core_start_o, busy_o} !== 4'd0) begin
      errors++;
      $display("FAIL idle_outputs got %b exp 0000", {px_ready_o, gray_valid_o, core_start_o, busy_o});
    end
    check_count(0);

    // White pixels back-to-back at full throughput.
    ready_mode = 0;
    start_frame();
    send(15'h7FFF, t_first);
    for (int k = 1; k < NPX; k++) send(15'h7FFF, t);
    px_valid_i = 1'b0;
    checks++;
    if (t - t_first != NPX - 1) begin
      errors++;
      $display("FAIL throughput got %0d cycles for %0d accepts exp %0d", t - t_first, NPX, NPX - 1);
    end
    got = 1'b0;
    t_done = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk_i);
      if (frame_done_o) begin got = 1'b1; t_done = cyc; end
    end
    checks++;
    if (!got || t_done - t != 2) begin
      errors++;
      $display("FAIL done_latency got %0d (seen %0b) exp 2", t_done - t, got);
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_done got %0b exp 1", busy_o);
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done got %0b exp 0", busy_o);
    end
    wait_idle();

    // Red held through a 5-cycle stall, then green follows with no bubble.
    ready_mode = 2;
    start_frame();
    send(15'h7C00, t);
    px_valid_i = 1'b1;
    px_rgb_i   = 15'h03E0;
    repeat (5) begin
      @(negedge clk_i);
      checks++;
      if (px_ready_o !== 1'b0 || gray_valid_o !== 1'b1 || gray_o !== 8'd69) begin
        errors++;
        $display("FAIL stall_hold got ready=%0b valid=%0b gray=%0d exp ready=0 valid=1 gray=69",
                 px_ready_o, gray_valid_o, gray_o);
      end
    end
    @(posedge clk_i); #1;
    ready_mode = 0;
    send(15'h03E0, t);
    send(15'($urandom()), t);
    send(15'($urandom()), t);
    px_valid_i = 1'b0;
    wait_idle();

    // Valid toggling 1/0 with blue pixels: each result is followed by a bubble.
    start_frame();
    for (int k = 0; k < NPX; k++) begin
      px_valid_i = 1'b1;
      px_rgb_i   = 15'h001F;
      @(negedge clk_i);
      checks++;
      if (px_ready_o !== 1'b1 || gray_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL toggle_accept got ready=%0b valid=%0b exp ready=1 valid=0", px_ready_o, gray_valid_o);
      end else begin
        push_exp(15'h001F);
      end
      @(posedge clk_i); #1;
      px_valid_i = 1'b0;
      px_rgb_i   = 15'($urandom());
      @(negedge clk_i);
      checks++;
      if (gray_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL toggle_valid got %0b exp 1", gray_valid_o);
      end
      @(posedge clk_i); #1;
    end
    wait_idle();

    // Random backpressure with a frame_start pulse mid-frame that must be ignored.
    ready_mode = 1;
    run_frame(1'b1);
    run_frame(1'b0);

    // Asynchronous reset while stalled after one accept.
    ready_mode = 2;
    @(posedge clk_i); #1;
    start_frame();
    send(15'($urandom()), t);
    px_valid_i = 1'b1;
    px_rgb_i   = 15'($urandom());
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if ({px_ready_o, gray_valid_o, eol_o, eof_o, frame_done_o, core_start_o, busy_o} !== 7'd0 ||
        core_px_rgb_o !== 15'd0) begin
      errors++;
      $display("FAIL async_reset got flags=%b core_rgb=%h exp flags=0000000 core_rgb=0000",
               {px_ready_o, gray_valid_o, eol_o, eof_o, frame_done_o, core_start_o, busy_o}, core_px_rgb_o);
    end
    exp_q.delete();
    pix_idx = 0;
    @(posedge clk_i); #1;
    px_valid_i = 1'b0;
    ready_mode = 0;
    reset_i    = 1'b0;
    @(posedge clk_i); #1;
    check_count(0);

    // Clean frames after reset, with frame counting when enabled.
    run_frame(1'b0);
    check_count(1);
    ready_mode = 1;
    run_frame(1'b0);
    check_count(2);
    run_frame(1'b0);
    check_count(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
